weight_fetch_arbiter: RTL and testbench

WEIGHT_FETCH_ARBITER -- requirements
Module: weight_fetch_arbiter

---
 rtl/weight_fetch_arbiter_pkg.sv | 17 +
 rtl/weight_fetch_arbiter_rr_arbiter2.sv | 24 ++
 rtl/weight_fetch_arbiter.sv | 102 ++++++++++
 tb/tb_weight_fetch_arbiter.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/weight_fetch_arbiter_pkg.sv
// Shared constants for the weight fetch arbiter: FSM encoding, default sizing
// and requester indices.
package weight_fetch_arbiter_pkg;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_FETCH   = 2'd1;
    localparam logic [1:0] ST_LAST    = 2'd2;
    localparam logic [1:0] ST_PRESENT = 2'd3;

    localparam int DEF_BIT_WIDTH = 8;
    localparam int DEF_SIZE      = 26;
    localparam int DEF_DEPTH     = 156;

    localparam int REQ_CONV = 0;
    localparam int REQ_FC   = 1;

endpackage

// File: rtl/weight_fetch_arbiter_rr_arbiter2.sv
// Two-way round-robin picker: a lone request wins, a tie goes to the
// requester that was not served last. Purely combinational.
module rr_arbiter2
    import weight_fetch_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_fc,
    output logic [1:0] win
);

    always_comb begin
        win = '0;
        case (req)
            2'b01: win[REQ_CONV] = 1'b1;
            2'b10: win[REQ_FC]   = 1'b1;
            2'b11: begin
                if (last_fc) win[REQ_CONV] = 1'b1;
                else         win[REQ_FC]   = 1'b1;
            end
            default: win = '0;
        endcase
    end

endmodule

// File: rtl/weight_fetch_arbiter.sv
// Arbitrates block fetches from an external 1-cycle-latency weight ROM between
// the conv and fc layers and presents each assembled block with a handshake.
module weight_fetch_arbiter
    import weight_fetch_arbiter_pkg::*;
#(
    parameter int BIT_WIDTH = DEF_BIT_WIDTH,
    parameter int SIZE      = DEF_SIZE,
    parameter int DEPTH     = DEF_DEPTH,
    parameter int ADDR_W    = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [1:0]                req,
    input  logic [ADDR_W-1:0]         base_addr0,
    input  logic [ADDR_W-1:0]         base_addr1,
    output logic [1:0]                grant,
    output logic                      rom_en,
    output logic [ADDR_W-1:0]         rom_addr,
    input  logic [BIT_WIDTH-1:0]      rom_data,
    output logic [BIT_WIDTH*SIZE-1:0] out,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      busy
);

    localparam int IDX_W = (SIZE > 1) ? $clog2(SIZE) : 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    logic [1:0]                      state;
    logic [IDX_W-1:0]                idx;
    logic                            last_fc;
    logic [1:0]                      win;
    logic [ADDR_W-1:0]               sel_base;
    logic [ADDR_W-1:0]               base_wrapped;
    logic [BIT_WIDTH*(SIZE-1)-1:0]   blk_q;

    rr_arbiter2 u_rr (
        .req     (req),
        .last_fc (last_fc),
        .win     (win)
    );

    assign sel_base     = win[REQ_FC] ? base_addr1 : base_addr0;
    assign base_wrapped = ADDR_W'(32'(sel_base) % 32'(DEPTH));
    assign busy         = (state != ST_IDLE);

    // Words are gathered in a shadow buffer and copied to out only when the
    // final word lands, so out holds the previous block throughout a fetch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            grant     <= '0;
            rom_en    <= 1'b0;
            rom_addr  <= '0;
            idx       <= '0;
            blk_q     <= '0;
            out       <= '0;
            out_valid <= 1'b0;
            last_fc   <= 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (win != 2'b00) begin
                        grant    <= win;
                        rom_en   <= 1'b1;
                        rom_addr <= base_wrapped;
                        idx      <= '0;
                        state    <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    for (int unsigned i = 0; i < SIZE - 1; i++) begin
                        if (idx == IDX_W'(i + 1))
                            blk_q[BIT_WIDTH*i +: BIT_WIDTH] <= rom_data;
                    end
                    if (idx == IDX_W'(SIZE - 1)) begin
                        rom_en <= 1'b0;
                        state  <= ST_LAST;
                    end else begin
                        idx      <= idx + IDX_W'(1);
                        rom_addr <= (rom_addr == LAST_ADDR) ? '0 : rom_addr + ADDR_W'(1);
                    end
                end
                ST_LAST: begin
                    out       <= {rom_data, blk_q};
                    out_valid <= 1'b1;
                    state     <= ST_PRESENT;
                end
                ST_PRESENT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        grant     <= '0;
                        last_fc   <= grant[REQ_FC];
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_weight_fetch_arbiter.sv
// Bench for weight_fetch_arbiter against a ROM model word[a] = a mod 256.
module tb_weight_fetch_arbiter;

    localparam int BW    = 8;
    localparam int SIZE  = 26;
    localparam int DEPTH = 156;
    localparam int AW    = 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [1:0]        req;
    logic [AW-1:0]     base_addr0, base_addr1;
    logic [1:0]        grant;
    logic              rom_en;
    logic [AW-1:0]     rom_addr;
    logic [BW-1:0]     rom_data = '0;
    logic [BW*SIZE-1:0] out;
    logic              out_valid;
    logic              out_ready;
    logic              busy;

    int n_checks = 0;
    int n_pass   = 0;
    int last_served = 1;
    logic [BW*SIZE-1:0] prev_block = '0;

    weight_fetch_arbiter #(
        .BIT_WIDTH (BW),
        .SIZE      (SIZE),
        .DEPTH     (DEPTH),
        .ADDR_W    (AW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .base_addr0 (base_addr0),
        .base_addr1 (base_addr1),
        .grant      (grant),
        .rom_en     (rom_en),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .out        (out),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) rom_data <= rom_en ? rom_addr : 8'hEE;

    task automatic chk(input string tag, input logic [BW*SIZE-1:0] obs, input logic [BW*SIZE-1:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic logic [1:0] pick(input logic [1:0] r);
        if (r == 2'b11) return (last_served == 1) ? 2'b01 : 2'b10;
        return r;
    endfunction

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_grant"}, grant, 0);
        chk({tag, "_rom_en"}, rom_en, 0);
        chk({tag, "_rom_addr"}, rom_addr, 0);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_out"}, out, 0);
    endtask

    // One full transfer, started at a negedge with the DUT in IDLE.
    task automatic xfer(input logic [1:0] r, input int b0, input int b1,
                        input int ready_delay, input bit drop);
        logic [1:0] w;
        int base;
        int a;
        logic [BW*SIZE-1:0] blk;
        req        = r;
        base_addr0 = AW'(b0);
        base_addr1 = AW'(b1);
        out_ready  = (ready_delay == 0);
        w    = pick(r);
        base = ((w == 2'b10) ? b1 : b0) % DEPTH;
        blk  = '0;
        for (int i = 0; i < SIZE; i++) begin
            a = (base + i) % DEPTH;
            blk[BW*i +: BW] = BW'(a % 256);
        end
        for (int k = 1; k <= SIZE + 1; k++) begin
            @(negedge clk);
            if (drop && k == 5) req = 2'b00;
            chk("grant_fetch", grant, w);
            chk("busy_fetch", busy, 1);
            chk("out_valid_fetch", out_valid, 0);
            if (k <= SIZE) begin
                chk("rom_en_fetch", rom_en, 1);
                chk("rom_addr", rom_addr, (base + k - 1) % DEPTH);
            end else begin
                chk("rom_en_last", rom_en, 0);
            end
            if (k == 1 || k == SIZE + 1) chk("out_hold", out, prev_block);
        end
        @(negedge clk);
        chk("out_valid_rise", out_valid, 1);
        chk("out_block", out, blk);
        chk("grant_present", grant, w);
        for (int d = 0; d < ready_delay; d++) begin
            @(negedge clk);
            chk("out_valid_wait", out_valid, 1);
            chk("out_stable_wait", out, blk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("out_valid_fall", out_valid, 0);
        chk("grant_clear", grant, 0);
        chk("busy_idle", busy, 0);
        chk("out_keep", out, blk);
        out_ready   = 1'b0;
        req         = 2'b00;
        last_served = (w == 2'b10) ? 1 : 0;
        prev_block  = blk;
    endtask

    initial begin
        rst_n      = 1'b0;
        req        = 2'b00;
        base_addr0 = '0;
        base_addr1 = '0;
        out_ready  = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;

        xfer(2'b01, 0, 0, 0, 0);
        xfer(2'b11, 26, 52, 0, 0);
        xfer(2'b11, 26, 52, 0, 0);
        xfer(2'b11, 26, 52, 0, 0);
        xfer(2'b10, 0, 140, 0, 0);
        xfer(2'b01, 200, 0, 10, 1);
        xfer(2'b10, 0, 255, 2, 0);

        for (int n = 0; n < 8; n++) begin
            xfer(2'($urandom_range(1, 3)), int'($urandom_range(0, 255)),
                 int'($urandom_range(0, 255)), int'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)));
        end

        // Mid-transfer reset: pointer says requester 1 would win the tie.
        xfer(2'b01, 3, 0, 0, 0);
        req        = 2'b11;
        base_addr0 = 8'd10;
        base_addr1 = 8'd20;
        repeat (11) @(negedge clk);
        chk("pre_reset_grant", grant, 2'b10);
        chk("pre_reset_addr", rom_addr, 30);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("async_reset");
        last_served = 1;
        prev_block  = '0;
        req = 2'b00;
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 32; k++) begin
            @(negedge clk);
            chk("no_valid_after_reset", out_valid, 0);
            chk("idle_after_reset", busy, 0);
        end
        xfer(2'b11, 40, 60, 1, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
